// File: rtl/usb_cmd_parser.sv
// usb_cmd_parser: hunts for the AA 55 frame header in the USB receive byte
// stream, captures command code and 16-bit length, buffers the payload while
// summing the checksum, and replays the payload over valid/ready only after
// the checksum byte matches.
// Optional feature: define USB_PARSER_TIMEOUT_EN to abort partial frames after
// TIMEOUT_CYCLES idle cycles between bytes.
module usb_cmd_parser #(
  parameter int MAX_PAYLOAD    = 128,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  usb_data_in,
  input  logic        usb_data_valid_in,
  output logic [7:0]  cmd_type,
  output logic [15:0] cmd_length,
  output logic        cmd_start,
  output logic [7:0]  cmd_data,
  output logic [15:0] cmd_data_index,
  output logic        cmd_data_valid,
  input  logic        cmd_data_ready,
  output logic        cmd_done,
  output logic        cmd_err,
  output logic        busy
);

  localparam int          AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_HDR2     = 4'd1;
  localparam logic [3:0] S_CMD      = 4'd2;
  localparam logic [3:0] S_LEN_H    = 4'd3;
  localparam logic [3:0] S_LEN_L    = 4'd4;
  localparam logic [3:0] S_PAYLOAD  = 4'd5;
  localparam logic [3:0] S_CHECKSUM = 4'd6;
  localparam logic [3:0] S_ISSUE    = 4'd7;
  localparam logic [3:0] S_REPLAY   = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;

  // Running frame checksum: plain 8-bit sum, wrapping mod 256.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    csum_add = sum + b;
  endfunction

  logic [3:0]  state_q, state_d;
  logic [7:0]  type_q, type_d;          // command code of the frame being received
  logic [15:0] len_q, len_d;            // length of the frame being received
  logic [15:0] cnt_q, cnt_d;            // payload bytes received so far
  logic [7:0]  sum_q, sum_d;
  logic [15:0] idx_q, idx_d;            // replay index, also the index output
  logic [7:0]  out_type_q, out_type_d;
  logic [15:0] out_len_q, out_len_d;
  logic        start_q, start_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [7:0]  rd_data_q;

  logic [7:0]    buf_mem [MAX_PAYLOAD];
  logic          wr_en_s;
  logic          rd_en_s;
  logic [AW-1:0] rd_addr_s;
  logic [15:0]   len_full_s;
  logic [15:0]   nxt_idx_s;

`ifdef USB_PARSER_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] to_cnt_q, to_cnt_d;      // cycles since the last received byte
`else
  // Without the timeout build a partial frame simply waits; the parameter is
  // kept so both builds share one parameter list.
  if (TIMEOUT_CYCLES < 0) begin : g_timeout_absent
  end
`endif

  // Next-state, datapath and output-register decode for the whole frame flow.
  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    idx_d      = idx_q;
    out_type_d = out_type_q;
    out_len_d  = out_len_q;
    start_d    = 1'b0;
    valid_d    = valid_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    wr_en_s    = 1'b0;
    rd_en_s    = 1'b0;
    rd_addr_s  = idx_q[AW-1:0];
    len_full_s = {len_q[15:8], usb_data_in};
    nxt_idx_s  = idx_q + 16'd1;
`ifdef USB_PARSER_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (usb_data_valid_in && (usb_data_in == 8'hAA)) begin
          state_d = S_HDR2;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR2: begin
        if (usb_data_valid_in) begin
          if (usb_data_in == 8'h55) begin
            state_d = S_CMD;
            sum_d   = 8'h00;
          end else if (usb_data_in == 8'hAA) begin
            state_d = S_HDR2;           // AA AA 55 resynchronises
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_HDR2;
        end
      end
      S_CMD: begin
        if (usb_data_valid_in) begin
          type_d  = usb_data_in;
          sum_d   = csum_add(sum_q, usb_data_in);
          state_d = S_LEN_H;
        end else begin
          state_d = S_CMD;
        end
      end
      S_LEN_H: begin
        if (usb_data_valid_in) begin
          len_d   = {usb_data_in, 8'h00};
          sum_d   = csum_add(sum_q, usb_data_in);
          state_d = S_LEN_L;
        end else begin
          state_d = S_LEN_H;
        end
      end
      S_LEN_L: begin
        if (usb_data_valid_in) begin
          len_d = len_full_s;
          sum_d = csum_add(sum_q, usb_data_in);
          cnt_d = 16'd0;
          if (len_full_s == 16'd0) begin
            state_d = S_CHECKSUM;
          end else if (len_full_s > MAX_LEN) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = S_PAYLOAD;
          end
        end else begin
          state_d = S_LEN_L;
        end
      end
      S_PAYLOAD: begin
        if (usb_data_valid_in) begin
          wr_en_s = 1'b1;
          sum_d   = csum_add(sum_q, usb_data_in);
          cnt_d   = cnt_q + 16'd1;
          if ((cnt_q + 16'd1) == len_q) begin
            state_d = S_CHECKSUM;
          end else begin
            state_d = S_PAYLOAD;
          end
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      S_CHECKSUM: begin
        if (usb_data_valid_in) begin
          if (usb_data_in == sum_q) begin
            state_d    = S_ISSUE;
            start_d    = 1'b1;
            out_type_d = type_q;
            out_len_d  = len_q;
            idx_d      = 16'd0;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end else begin
          state_d = S_CHECKSUM;
        end
      end
      S_ISSUE: begin
        rd_en_s = 1'b1;                 // fetch byte 0 so it is ready with valid
        err_d   = usb_data_valid_in;
        if (len_q == 16'd0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_REPLAY;
          valid_d = 1'b1;
        end
      end
      S_REPLAY: begin
        rd_en_s = 1'b1;
        err_d   = usb_data_valid_in;
        if (valid_q && cmd_data_ready) begin
          if (idx_q == (len_q - 16'd1)) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d     = nxt_idx_s;
            rd_addr_s = nxt_idx_s[AW-1:0];   // prefetch: no bubble between handshakes
            state_d   = S_REPLAY;
          end
        end else begin
          state_d = S_REPLAY;
        end
      end
      S_DONE: begin
        err_d   = usb_data_valid_in;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

`ifdef USB_PARSER_TIMEOUT_EN
    if ((state_q == S_HDR2) || (state_q == S_CMD) || (state_q == S_LEN_H) ||
        (state_q == S_LEN_L) || (state_q == S_PAYLOAD) || (state_q == S_CHECKSUM)) begin
      if (usb_data_valid_in) begin
        to_cnt_d = 32'd1;
      end else if (to_cnt_q >= TO_LAST) begin
        to_cnt_d = 32'd0;
        state_d  = S_IDLE;
        err_d    = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 32'd1;
      end
    end else if (state_q == S_IDLE) begin
      to_cnt_d = usb_data_valid_in ? 32'd1 : 32'd0;
    end else begin
      to_cnt_d = to_cnt_q;              // frozen while a verified frame is issued
    end
`endif

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any frame without a done/err pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      type_q     <= 8'h00;
      len_q      <= 16'd0;
      cnt_q      <= 16'd0;
      sum_q      <= 8'h00;
      idx_q      <= 16'd0;
      out_type_q <= 8'h00;
      out_len_q  <= 16'd0;
      start_q    <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef USB_PARSER_TIMEOUT_EN
      to_cnt_q   <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      idx_q      <= idx_d;
      out_type_q <= out_type_d;
      out_len_q  <= out_len_d;
      start_q    <= start_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
`ifdef USB_PARSER_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  // Payload buffer write port (plain RAM, no reset).
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      buf_mem[cnt_q[AW-1:0]] <= usb_data_in;
    end
  end

  // Registered read port; only updates while issuing so cmd_data stays 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= 8'h00;
    end else if (rd_en_s) begin
      rd_data_q <= buf_mem[rd_addr_s];
    end
  end

  assign cmd_type       = out_type_q;
  assign cmd_length     = out_len_q;
  assign cmd_start      = start_q;
  assign cmd_data       = rd_data_q;
  assign cmd_data_index = idx_q;
  assign cmd_data_valid = valid_q;
  assign cmd_done       = done_q;
  assign cmd_err        = err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_usb_cmd_parser.sv
// Self-checking bench for usb_cmd_parser: frames are built from fields, the
// bench derives the expected checksum, pulse cycles and replay data from the
// frame rules, and one compare process checks the outputs every cycle.
module tb_usb_cmd_parser;

  localparam int MAXP = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  usb_data_in = 8'h00;
  logic        usb_data_valid_in = 1'b0;
  logic [7:0]  cmd_type;
  logic [15:0] cmd_length;
  logic        cmd_start;
  logic [7:0]  cmd_data;
  logic [15:0] cmd_data_index;
  logic        cmd_data_valid;
  logic        cmd_data_ready = 1'b1;
  logic        cmd_done;
  logic        cmd_err;
  logic        busy;

  usb_cmd_parser #(.MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .usb_data_in(usb_data_in), .usb_data_valid_in(usb_data_valid_in),
    .cmd_type(cmd_type), .cmd_length(cmd_length), .cmd_start(cmd_start),
    .cmd_data(cmd_data), .cmd_data_index(cmd_data_index),
    .cmd_data_valid(cmd_data_valid), .cmd_data_ready(cmd_data_ready),
    .cmd_done(cmd_done), .cmd_err(cmd_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- expectation model ----------------
  typedef struct { int cyc; logic [7:0] typ; logic [15:0] len; } start_t;
  typedef struct { logic [7:0] d; logic [15:0] idx; bit last; } data_t;
  start_t     start_q[$];
  int         err_q[$];
  data_t      data_q[$];
  logic [7:0] frame_pl[$];

  function automatic logic [7:0] model_csum(input logic [7:0] typ, input logic [15:0] len);
    int s;
    s = int'(typ) + int'(len[15:8]) + int'(len[7:0]);
    foreach (frame_pl[i]) s += int'(frame_pl[i]);
    return 8'(s % 256);
  endfunction

  // ---------------- per-cycle compare ----------------
  bit         rep_active = 1'b0;
  int         rep_from = 0;
  int         done_due = -1;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_d = 8'h00;
  logic [15:0] prev_i = 16'd0;

  always @(negedge clk) begin : cmp
    bit     exp_s, exp_e, exp_v;
    start_t sh;
    data_t  dh;
    if (!rst_n) begin
      check({cmd_type, cmd_length, cmd_data} == 32'd0, "reset_fields",
            {cmd_type, cmd_length, cmd_data}, 32'd0);
      check({cmd_data_index, cmd_start, cmd_done, cmd_err, cmd_data_valid, busy} == 21'd0,
            "reset_ctrl", {cmd_data_index, cmd_start, cmd_done, cmd_err, cmd_data_valid, busy}, 32'd0);
      rep_active = 1'b0;
      done_due   = -1;
      prev_hold  = 1'b0;
    end else begin
      exp_s = (start_q.size() > 0) && (start_q[0].cyc == cyc);
      check(cmd_start == exp_s, "cmd_start", cmd_start, exp_s);
      if (exp_s) begin
        sh = start_q[0];
        check(cmd_type == sh.typ, "cmd_type", cmd_type, sh.typ);
        check(cmd_length == sh.len, "cmd_length", cmd_length, sh.len);
        if (sh.len == 16'd0) done_due = cyc + 1;
        else begin
          rep_active = 1'b1;
          rep_from   = cyc + 1;
        end
      end
      while ((start_q.size() > 0) && (start_q[0].cyc <= cyc)) void'(start_q.pop_front());

      exp_e = (err_q.size() > 0) && (err_q[0] == cyc);
      check(cmd_err == exp_e, "cmd_err", cmd_err, exp_e);
      while ((err_q.size() > 0) && (err_q[0] <= cyc)) void'(err_q.pop_front());

      check(cmd_done == (done_due == cyc), "cmd_done", cmd_done, (done_due == cyc));

      exp_v = rep_active && (cyc >= rep_from);
      check(cmd_data_valid == exp_v, "cmd_data_valid", cmd_data_valid, exp_v);

      if (prev_hold && cmd_data_valid) begin
        check(cmd_data == prev_d, "hold_data", cmd_data, prev_d);
        check(cmd_data_index == prev_i, "hold_index", cmd_data_index, prev_i);
      end

      if (cmd_data_valid && cmd_data_ready) begin
        if (data_q.size() == 0) begin
          check(1'b0, "unexpected_byte", cmd_data, 32'd0);
        end else begin
          dh = data_q.pop_front();
          check(cmd_data == dh.d, "cmd_data", cmd_data, dh.d);
          check(cmd_data_index == dh.idx, "cmd_data_index", cmd_data_index, dh.idx);
          if (dh.last) begin
            rep_active = 1'b0;
            done_due   = cyc + 1;
          end
        end
      end
      prev_hold = cmd_data_valid && !cmd_data_ready;
      prev_d    = cmd_data;
      prev_i    = cmd_data_index;

      if (cmd_start || cmd_data_valid || cmd_done) check(busy == 1'b1, "busy_active", busy, 1'b1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic put(input logic [7:0] b);
    @(posedge clk); #1;
    usb_data_in       = b;
    usb_data_valid_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      usb_data_valid_in = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] typ, input bit corrupt);
    logic [15:0] len;
    logic [7:0]  cs;
    start_t      st;
    data_t       de;
    len = 16'(frame_pl.size());
    cs  = model_csum(typ, len);
    if (corrupt) cs = cs + 8'd1;
    put(8'hAA); put(8'h55); put(typ); put(len[15:8]); put(len[7:0]);
    foreach (frame_pl[i]) put(frame_pl[i]);
    put(cs);
    if (corrupt) err_q.push_back(cyc + 1);
    else begin
      st.cyc = cyc + 1; st.typ = typ; st.len = len;
      start_q.push_back(st);
      foreach (frame_pl[i]) begin
        de.d = frame_pl[i]; de.idx = 16'(i); de.last = (i == frame_pl.size() - 1);
        data_q.push_back(de);
      end
    end
  endtask

  task automatic ready_wave(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      usb_data_valid_in = 1'b0;
      cmd_data_ready    = ~cmd_data_ready;
    end
    cmd_data_ready = 1'b1;
  endtask

  initial begin : stim
    start_t st;
    idle(3);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);

    // single-byte frame
    frame_pl = '{8'h50};
    check(model_csum(8'h04, 16'd1) == 8'h55, "pin_csum_1", model_csum(8'h04, 16'd1), 8'h55);
    send_frame(8'h04, 1'b0);
    idle(6);

    // six bytes with ready toggling
    frame_pl = '{8'h00, 8'h3C, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    check(model_csum(8'h05, 16'd6) == 8'h7F, "pin_csum_2", model_csum(8'h05, 16'd6), 8'h7F);
    send_frame(8'h05, 1'b0);
    ready_wave(20);
    idle(4);

    // bad checksum then the correct frame
    frame_pl = '{8'h00, 8'h3C, 8'h00, 8'h04};
    check(model_csum(8'h06, 16'd4) == 8'h4A, "pin_csum_3", model_csum(8'h06, 16'd4), 8'h4A);
    send_frame(8'h06, 1'b1);
    idle(2);
    send_frame(8'h06, 1'b0);
    idle(8);

    // resync on AA AA 55 with zero-length frame
    put(8'h13); put(8'hAA); put(8'hAA); put(8'h55); put(8'h04); put(8'h00); put(8'h00); put(8'h04);
    st.cyc = cyc + 1; st.typ = 8'h04; st.len = 16'd0;
    start_q.push_back(st);
    idle(4);

    // oversize length 0x0081
    put(8'hAA); put(8'h55); put(8'h07); put(8'h00); put(8'h81);
    err_q.push_back(cyc + 1);
    idle(3);

    // maximum length is accepted
    frame_pl.delete();
    for (int i = 0; i < MAXP; i++) frame_pl.push_back(8'(i * 7 + 3));
    send_frame(8'h0A, 1'b0);
    idle(MAXP + 6);

    // overrun during replay with ready low
    cmd_data_ready = 1'b0;
    frame_pl = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h09, 1'b0);
    idle(2);
    put(8'hAA); err_q.push_back(cyc + 1);
    put(8'h55); err_q.push_back(cyc + 1);
    idle(3);
    cmd_data_ready = 1'b1;
    idle(6);
    frame_pl = '{8'h50};
    send_frame(8'h04, 1'b0);
    idle(6);

    // reset mid-payload
    put(8'hAA); put(8'h55); put(8'h04); put(8'h00); put(8'h05); put(8'h11); put(8'h22);
    idle(1);
    @(posedge clk); #1; rst_n = 1'b0;
    idle(3);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);
    check(busy == 1'b0, "busy_after_reset", busy, 1'b0);
    frame_pl = '{8'h01, 8'h02};
    send_frame(8'h02, 1'b0);
    idle(8);

`ifdef USB_PARSER_TIMEOUT_EN
    put(8'hAA); put(8'h55); put(8'h04);
    err_q.push_back(cyc + 100);
    idle(110);
    frame_pl = '{8'h50};
    send_frame(8'h04, 1'b0);
    idle(6);
`endif

    idle(4);
    check(start_q.size() == 0, "pending_start", start_q.size(), 32'd0);
    check(err_q.size() == 0, "pending_err", err_q.size(), 32'd0);
    check(data_q.size() == 0, "pending_data", data_q.size(), 32'd0);
    check(busy == 1'b0, "busy_idle_end", busy, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_cmd_parser.md
# usb_cmd_parser

Front-end frame parser between the USB receive byte stream and the command handlers (I2C config/write/read and siblings). It hunts for the `AA 55` header, captures command code and 16-bit length, and buffers the payload while accumulating the checksum. Payload is released downstream over a valid/ready handshake only after the checksum matches, so handlers never act on corrupt frames.

## Interface
- `MAX_PAYLOAD`, 128: payload buffer depth in bytes; also the maximum accepted frame length.
- `TIMEOUT_CYCLES`, 50_000_000: inter-byte timeout in `clk` cycles (1 s at 50 MHz); used only with the timeout macro.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `usb_data_in`  in  8  received byte.
- `usb_data_valid_in`  in  1  one-cycle strobe per byte; at most one byte per cycle; no backpressure.
- `cmd_type`  out  8  command code of the current frame; held from `cmd_start` to `cmd_done`.
- `cmd_length`  out  16  payload length of the current frame; held like `cmd_type`.
- `cmd_start`  out  1  one-cycle pulse: frame verified, replay begins.
- `cmd_data`  out  8  payload byte.
- `cmd_data_index`  out  16  index of `cmd_data` within the payload, from 0.
- `cmd_data_valid`  out  1  `cmd_data` and `cmd_data_index` valid.
- `cmd_data_ready`  in  1  downstream accepts the byte.
- `cmd_done`  out  1  one-cycle pulse after the last payload handshake.
- `cmd_err`  out  1  one-cycle pulse: checksum mismatch, oversize length, overrun, or timeout.
- `busy`  out  1  high in every state except `IDLE`.

## Operation
- States: `IDLE`, `HDR2`, `CMD`, `LEN_H`, `LEN_L`, `PAYLOAD`, `CHECKSUM`, `ISSUE`, `REPLAY`, `DONE`. Transitions in receive states (`IDLE` through `CHECKSUM`) occur only on `usb_data_valid_in`.
- `IDLE`: byte `AA` goes to `HDR2`; any other byte is ignored.
- `HDR2`: byte `55` goes to `CMD`; byte `AA` stays in `HDR2`, so `AA AA 55` resyncs; any other byte returns to `IDLE`.
- `CMD`, `LEN_H`, `LEN_L`: latch the field and advance. In `LEN_L`, length 0 goes to `CHECKSUM`; length > `MAX_PAYLOAD` pulses `cmd_err` and returns to `IDLE`; otherwise go to `PAYLOAD`.
- `PAYLOAD`: write the byte to buffer[count] and increment count. On count == length, go to `CHECKSUM`.
- Checksum: 8-bit running sum mod 256 of cmd, len_hi, len_lo and every payload byte. Header bytes and the checksum byte itself are excluded. The sum is cleared on entry to `CMD`.
- `CHECKSUM`: if the byte equals the sum, go to `ISSUE`; otherwise pulse `cmd_err` and go to `IDLE`.
- `ISSUE`: drive `cmd_start` for one cycle. Go to `REPLAY`, or to `DONE` if length is 0.
- `REPLAY`: present buffer[idx] with `cmd_data_valid`. Data and index hold stable until `cmd_data_ready`. After the handshake on idx == length-1, go to `DONE`.
- `DONE`: pulse `cmd_done` for one cycle, then go to `IDLE`.
- Bytes arriving in `ISSUE`, `REPLAY` or `DONE` are dropped and pulse `cmd_err` (overrun). The frame being replayed completes unaffected.
- Reset values: all outputs 0, state `IDLE`, sum 0, counters 0. An asserted reset mid-frame or mid-replay aborts immediately with no `cmd_done` or `cmd_err`.

## Timing
- `cmd_start` rises in the cycle after the checksum byte's valid strobe.
- The first `cmd_data_valid` rises in the cycle after `cmd_start`.
- With `cmd_data_ready` held high, one byte transfers per cycle. `cmd_done` follows the last handshake by one cycle.
- `cmd_err` for a bad checksum or oversize length rises in the cycle after the offending byte's strobe.
- The parser accepts the next `AA` in the cycle after `cmd_done` or `cmd_err`.
- The buffer is a registered-read RAM. The next byte is prefetched so back-to-back handshakes have no bubble.

## Configuration
- `USB_PARSER_TIMEOUT_EN` defined: in receive states other than `IDLE`, a counter of cycles since the last byte runs. When it reaches `TIMEOUT_CYCLES` the parser pulses `cmd_err` and returns to `IDLE`. The counter is frozen in `ISSUE`, `REPLAY` and `DONE`.
- Undefined: no timeout logic. A partial frame waits indefinitely.

## Test plan
- Send `AA 55 04 00 01 50 55` -> `cmd_start` with `cmd_type`=04 and `cmd_length`=1; one byte 50 at index 0; `cmd_done`; no `cmd_err`.
- Send `AA 55 05 00 06 00 3C DE AD BE EF 7F`, then toggle `cmd_data_ready` 1/0 -> bytes 00 3C DE AD BE EF at indices 0..5, each held stable while ready is low; then `cmd_done`.
- Send `AA 55 06 00 04 00 3C 00 04 4B` (correct checksum is 4A) -> `cmd_err` pulse; no `cmd_start`. A following correct frame ending `4A` is accepted.
- Send `13 AA AA 55 04 00 00 04` -> resync on `AA AA 55`; zero-length frame gives `cmd_start`, then `cmd_done` one cycle later.
- Send a frame with length 0x0081 -> `cmd_err` after the `LEN_L` byte. Send `AA 55` during `REPLAY` with ready low -> overrun `cmd_err`; the replay still completes. Assert `rst_n` low mid-payload -> outputs 0, state `IDLE`.
- With `USB_PARSER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100, send `AA 55 04` and stop -> `cmd_err` 100 cycles after the last byte; the next full frame is parsed normally.
